// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch_unit
//  Purpose  : Fetches 4-bit opcodes from a combinational program ROM and
//             presents them to the execute stage over a valid/ready
//             handshake. Skip-if-nonzero opcodes (SNZ A = 4'b1000,
//             SNZ S = 4'b1001) park the unit until execute reports whether
//             the following instruction is to be skipped. The unit halts
//             once the program counter runs past PROG_LAST.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   1           clock, rising edge active
//    reset         in   1           synchronous active-high reset
//    enableIn      in   1           run permission (used in IDLE and FETCH)
//    romAddrOut    out  ADDR_WIDTH  ROM address (equals pcOut)
//    romDataIn     in   4           ROM opcode at romAddrOut
//    instrOut      out  4           registered opcode for execute
//    instrValidOut out  1           instrOut is valid
//    instrReadyIn  in   1           execute accepts instrOut
//    condValidIn   in   1           skip decision for the last SNZ is valid
//    condTakenIn   in   1           skip the next instruction
//    pcOut         out  ADDR_WIDTH  low bits of the program counter
//    haltOut       out  1           program finished
// ============================================================================
module instruction_fetch_unit #(
    parameter int ADDR_WIDTH = 8,
    parameter int PROG_LAST  = 2**ADDR_WIDTH - 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enableIn,
    output logic [ADDR_WIDTH-1:0] romAddrOut,
    input  logic [3:0]            romDataIn,
    output logic [3:0]            instrOut,
    output logic                  instrValidOut,
    input  logic                  instrReadyIn,
    input  logic                  condValidIn,
    input  logic                  condTakenIn,
    output logic [ADDR_WIDTH-1:0] pcOut,
    output logic                  haltOut
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_COND = 3'd3,
        S_HALT      = 3'd4
    } state_t;

    // The PC carries one extra bit so running past PROG_LAST is visible
    // rather than wrapping back to address zero.
    localparam logic [ADDR_WIDTH:0] c_prog_last = (ADDR_WIDTH+1)'(PROG_LAST);
    localparam logic [ADDR_WIDTH:0] c_pc_one    = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] c_pc_zero   = '0;
    localparam logic [3:0]          c_op_nop    = 4'b0111;
    localparam logic [3:0]          c_op_snz_a  = 4'b1000;
    localparam logic [3:0]          c_op_snz_s  = 4'b1001;

    state_t              r_state_q, w_state_d;
    logic [ADDR_WIDTH:0] r_pc_q,    w_pc_d;
    logic [3:0]          r_instr_q, w_instr_d;
    logic                r_valid_q, w_valid_d;
    logic                r_halt_q,  w_halt_d;

    logic                w_is_snz;
    logic                w_skip;

    assign w_is_snz = (r_instr_q == c_op_snz_a) || (r_instr_q == c_op_snz_s);
    assign w_skip   = condTakenIn;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        w_pc_d    = r_pc_q;
        w_instr_d = r_instr_q;

        case (r_state_q)
            S_IDLE: begin
                if (enableIn) begin
                    w_state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                // The PC is advanced here, so during ISSUE it already points
                // at the next instruction; the halt test uses that value.
                if (enableIn) begin
                    w_instr_d = romDataIn;
                    w_pc_d    = r_pc_q + c_pc_one;
                    w_state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (instrReadyIn) begin
                    if (w_is_snz) begin
                        w_state_d = S_WAIT_COND;
                    end else if (r_pc_q > c_prog_last) begin
                        w_state_d = S_HALT;
                    end else begin
                        w_state_d = S_FETCH;
                    end
                end
            end

            S_WAIT_COND: begin
                if (condValidIn) begin
                    w_pc_d    = w_skip ? (r_pc_q + c_pc_one) : r_pc_q;
                    w_state_d = (w_pc_d > c_prog_last) ? S_HALT : S_FETCH;
                end
            end

            S_HALT: begin
                w_state_d = S_HALT;
            end

            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        w_valid_d = (w_state_d == S_ISSUE);
        w_halt_d  = (w_state_d == S_HALT);
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= S_IDLE;
            r_pc_q    <= c_pc_zero;
            r_instr_q <= c_op_nop;
            r_valid_q <= 1'b0;
            r_halt_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_pc_q    <= w_pc_d;
            r_instr_q <= w_instr_d;
            r_valid_q <= w_valid_d;
            r_halt_q  <= w_halt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign romAddrOut    = r_pc_q[ADDR_WIDTH-1:0];
    assign pcOut         = r_pc_q[ADDR_WIDTH-1:0];
    assign instrOut      = r_instr_q;
    assign instrValidOut = r_valid_q;
    assign haltOut       = r_halt_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instruction_fetch_unit
//  Purpose  : Directed self-checking bench for instruction_fetch_unit with a
//             16-entry ROM, ADDR_WIDTH=4 and PROG_LAST=7.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    localparam int AW = 4;
    localparam int PL = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enableIn = 1'b0;
    logic          instrReadyIn = 1'b0;
    logic          condValidIn = 1'b0;
    logic          condTakenIn = 1'b0;
    logic [AW-1:0] romAddrOut;
    logic [AW-1:0] pcOut;
    logic [3:0]    romDataIn;
    logic [3:0]    instrOut;
    logic          instrValidOut;
    logic          haltOut;

    logic [3:0]    rom [16];

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    // Every completed handshake: opcode, its ROM address, and the cycle.
    logic [3:0]    log_op   [$];
    logic [AW-1:0] log_addr [$];
    int            log_cyc  [$];

    instruction_fetch_unit #(
        .ADDR_WIDTH (AW),
        .PROG_LAST  (PL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enableIn      (enableIn),
        .romAddrOut    (romAddrOut),
        .romDataIn     (romDataIn),
        .instrOut      (instrOut),
        .instrValidOut (instrValidOut),
        .instrReadyIn  (instrReadyIn),
        .condValidIn   (condValidIn),
        .condTakenIn   (condTakenIn),
        .pcOut         (pcOut),
        .haltOut       (haltOut)
    );

    assign romDataIn = rom[romAddrOut];

    always #5 clk = ~clk;

    // pcOut has already advanced past the issued address while in ISSUE.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && instrValidOut && instrReadyIn) begin
            log_op.push_back(instrOut);
            log_addr.push_back(AW'(pcOut - 4'd1));
            log_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // img nibbles, most significant first, are ROM addresses 0..7.
    task automatic load_rom(input logic [31:0] img);
        for (int i = 0; i < 16; i++) rom[i] = 4'h0;
        for (int i = 0; i < 8; i++) rom[i] = img[31-4*i -: 4];
    endtask

    task automatic do_reset();
        reset = 1'b1; enableIn = 1'b0; instrReadyIn = 1'b0;
        condValidIn = 1'b0; condTakenIn = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic wait_issues(input int n, input int base, input int limit, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < limit && !ok; k++) begin
            if (log_op.size() - base >= n) ok = 1'b1;
            else tick();
        end
        if (log_op.size() - base >= n) ok = 1'b1;
    endtask

    task automatic wait_halt(input int limit, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < limit && !ok; k++) begin
            if (haltOut === 1'b1) ok = 1'b1;
            else tick();
        end
        if (haltOut === 1'b1) ok = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        load_rom(32'h01A2B2E2);
        enableIn = 1'b1; condValidIn = 1'b1; condTakenIn = 1'b1; instrReadyIn = 1'b1;
        reset = 1'b1;
        tick();
        tests_run++; if (pcOut !== 4'd0) begin tests_failed++; $display("FAIL reset_pc: got %0d expected 0", pcOut); end
        tests_run++; if (instrOut !== 4'b0111) begin tests_failed++; $display("FAIL reset_instr: got %h expected 7", instrOut); end
        tests_run++; if (instrValidOut !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", instrValidOut); end
        tests_run++; if (haltOut !== 1'b0) begin tests_failed++; $display("FAIL reset_halt: got %b expected 0", haltOut); end
        do_reset();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_straight_line();
        bit ok; int base; logic [31:0] img;
        img = 32'h01A2B2E2;
        load_rom(img);
        do_reset();
        base = log_op.size();
        // Condition strobes outside WAIT_COND must have no effect.
        instrReadyIn = 1'b1; condValidIn = 1'b1; condTakenIn = 1'b1;
        enableIn = 1'b1;
        tick();
        tests_run++; if (instrValidOut !== 1'b0) begin tests_failed++; $display("FAIL latency_edge1: valid got %b expected 0", instrValidOut); end
        tick();
        tests_run++; if (instrValidOut !== 1'b1) begin tests_failed++; $display("FAIL latency_edge2: valid got %b expected 1", instrValidOut); end
        tests_run++; if (instrOut !== 4'h0) begin tests_failed++; $display("FAIL first_instr: got %h expected 0", instrOut); end
        wait_halt(60, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL straight_halt_timeout: halt got 0 expected 1"); end
        tests_run++; if (log_op.size() - base !== 8) begin tests_failed++; $display("FAIL straight_count: got %0d expected 8", log_op.size() - base); end
        if (log_op.size() - base >= 8) begin
            for (int i = 0; i < 8; i++) begin
                tests_run++; if (log_op[base+i] !== img[31-4*i -: 4]) begin tests_failed++; $display("FAIL straight_op[%0d]: got %h expected %h", i, log_op[base+i], img[31-4*i -: 4]); end
                tests_run++; if (log_addr[base+i] !== AW'(i)) begin tests_failed++; $display("FAIL straight_addr[%0d]: got %0d expected %0d", i, log_addr[base+i], i); end
                if (i > 0) begin
                    tests_run++; if (log_cyc[base+i] - log_cyc[base+i-1] !== 2) begin tests_failed++; $display("FAIL straight_spacing[%0d]: got %0d expected 2", i, log_cyc[base+i] - log_cyc[base+i-1]); end
                end
            end
        end
        tests_run++; if (pcOut !== 4'd8) begin tests_failed++; $display("FAIL straight_halt_pc: got %0d expected 8", pcOut); end
        tests_run++; if (instrValidOut !== 1'b0) begin tests_failed++; $display("FAIL straight_halt_valid: got %b expected 0", instrValidOut); end
        enableIn = 1'b0; condValidIn = 1'b0; condTakenIn = 1'b0;
        tick(); tick(); tick();
        tests_run++; if (haltOut !== 1'b1) begin tests_failed++; $display("FAIL halt_sticky: got %b expected 1", haltOut); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_snz_taken();
        bit ok; int base; bit saw5;
        load_rom(32'h01238562);
        do_reset();
        base = log_op.size();
        instrReadyIn = 1'b1; enableIn = 1'b1;
        wait_issues(5, base, 40, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL snz_t_timeout: issues got %0d expected 5", log_op.size() - base); end
        if (ok) begin
            tests_run++; if (log_op[base+4] !== 4'h8) begin tests_failed++; $display("FAIL snz_t_op: got %h expected 8", log_op[base+4]); end
        end
        // WAIT_COND cycles 1 and 2
        for (int w = 1; w <= 2; w++) begin
            tests_run++; if (instrValidOut !== 1'b0) begin tests_failed++; $display("FAIL snz_t_wait_valid[%0d]: got %b expected 0", w, instrValidOut); end
            tick();
        end
        tests_run++; if (instrValidOut !== 1'b0) begin tests_failed++; $display("FAIL snz_t_wait_valid[3]: got %b expected 0", instrValidOut); end
        tests_run++; if (pcOut !== 4'd5) begin tests_failed++; $display("FAIL snz_t_wait_pc: got %0d expected 5", pcOut); end
        condValidIn = 1'b1; condTakenIn = 1'b1;
        tick();
        condValidIn = 1'b0; condTakenIn = 1'b0;
        tests_run++; if (pcOut !== 4'd6) begin tests_failed++; $display("FAIL snz_t_skip_pc: got %0d expected 6", pcOut); end
        wait_halt(40, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL snz_t_halt_timeout: halt got 0 expected 1"); end
        tests_run++; if (log_op.size() - base !== 7) begin tests_failed++; $display("FAIL snz_t_count: got %0d expected 7", log_op.size() - base); end
        if (log_op.size() - base >= 6) begin
            tests_run++; if (log_op[base+5] !== 4'h6) begin tests_failed++; $display("FAIL snz_t_next_op: got %h expected 6", log_op[base+5]); end
        end
        saw5 = 1'b0;
        for (int i = base; i < log_addr.size(); i++) if (log_addr[i] === 4'd5) saw5 = 1'b1;
        tests_run++; if (saw5) begin tests_failed++; $display("FAIL snz_t_addr5_issued: got 1 expected 0"); end
        tests_run++; if (pcOut !== 4'd8) begin tests_failed++; $display("FAIL snz_t_halt_pc: got %0d expected 8", pcOut); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_snz_not_taken();
        bit ok; int base;
        load_rom(32'h01238562);
        do_reset();
        base = log_op.size();
        instrReadyIn = 1'b1; enableIn = 1'b1;
        wait_issues(5, base, 40, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL snz_n_timeout: issues got %0d expected 5", log_op.size() - base); end
        condValidIn = 1'b1; condTakenIn = 1'b0;
        tick();
        condValidIn = 1'b0;
        tests_run++; if (pcOut !== 4'd5) begin tests_failed++; $display("FAIL snz_n_pc: got %0d expected 5", pcOut); end
        wait_halt(40, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL snz_n_halt_timeout: halt got 0 expected 1"); end
        tests_run++; if (log_op.size() - base !== 8) begin tests_failed++; $display("FAIL snz_n_count: got %0d expected 8", log_op.size() - base); end
        if (log_op.size() - base >= 6) begin
            tests_run++; if (log_op[base+5] !== 4'h5) begin tests_failed++; $display("FAIL snz_n_next_op: got %h expected 5", log_op[base+5]); end
            tests_run++; if (log_addr[base+5] !== 4'd5) begin tests_failed++; $display("FAIL snz_n_next_addr: got %0d expected 5", log_addr[base+5]); end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_backpressure();
        bit ok; int base;
        load_rom(32'h01A2B2E2);
        do_reset();
        base = log_op.size();
        instrReadyIn = 1'b0; enableIn = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 10 && !ok; k++) begin
            if (instrValidOut === 1'b1) ok = 1'b1; else tick();
        end
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL bp_valid_timeout: valid got 0 expected 1"); end
        for (int s = 0; s < 5; s++) begin
            tick();
            tests_run++; if (instrOut !== 4'h0 || pcOut !== 4'd1 || instrValidOut !== 1'b1) begin
                tests_failed++; $display("FAIL bp_hold[%0d]: got instr=%h pc=%0d valid=%b expected instr=0 pc=1 valid=1", s, instrOut, pcOut, instrValidOut);
            end
        end
        tests_run++; if (log_op.size() - base !== 0) begin tests_failed++; $display("FAIL bp_no_issue: got %0d expected 0", log_op.size() - base); end
        instrReadyIn = 1'b1;
        tick();
        tests_run++; if (log_op.size() - base !== 1) begin tests_failed++; $display("FAIL bp_one_issue: got %0d expected 1", log_op.size() - base); end
        tests_run++; if (instrValidOut !== 1'b0) begin tests_failed++; $display("FAIL bp_valid_drop: got %b expected 0", instrValidOut); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_snz_at_end();
        bit ok; int base; bit saw7;
        load_rom(32'h01234592);
        do_reset();
        base = log_op.size();
        instrReadyIn = 1'b1; enableIn = 1'b1;
        wait_issues(7, base, 40, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL end_timeout: issues got %0d expected 7", log_op.size() - base); end
        if (ok) begin
            tests_run++; if (log_op[base+6] !== 4'h9) begin tests_failed++; $display("FAIL end_snz_op: got %h expected 9", log_op[base+6]); end
        end
        condValidIn = 1'b1; condTakenIn = 1'b1;
        tick();
        condValidIn = 1'b0; condTakenIn = 1'b0;
        tests_run++; if (haltOut !== 1'b1) begin tests_failed++; $display("FAIL end_halt: got %b expected 1", haltOut); end
        tests_run++; if (pcOut !== 4'd8) begin tests_failed++; $display("FAIL end_pc: got %0d expected 8", pcOut); end
        tick(); tick(); tick();
        saw7 = 1'b0;
        for (int i = base; i < log_addr.size(); i++) if (log_addr[i] === 4'd7) saw7 = 1'b1;
        tests_run++; if (saw7 || log_op.size() - base !== 7) begin tests_failed++; $display("FAIL end_last_issued: got count=%0d addr7=%b expected count=7 addr7=0", log_op.size() - base, saw7); end
        tests_run++; if (instrValidOut !== 1'b0) begin tests_failed++; $display("FAIL end_valid: got %b expected 0", instrValidOut); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_recovery();
        bit ok; int base;
        // Reset while parked in WAIT_COND, with competing inputs active.
        load_rom(32'h01238562);
        do_reset();
        base = log_op.size();
        instrReadyIn = 1'b1; enableIn = 1'b1;
        wait_issues(5, base, 40, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL rw_timeout: issues got %0d expected 5", log_op.size() - base); end
        reset = 1'b1; condValidIn = 1'b1; condTakenIn = 1'b1;
        tick();
        tests_run++; if (pcOut !== 4'd0 || instrOut !== 4'b0111 || instrValidOut !== 1'b0 || haltOut !== 1'b0) begin
            tests_failed++; $display("FAIL rw_state: got pc=%0d instr=%h valid=%b halt=%b expected pc=0 instr=7 valid=0 halt=0", pcOut, instrOut, instrValidOut, haltOut);
        end
        reset = 1'b0; condValidIn = 1'b0; condTakenIn = 1'b0;
        base = log_op.size();
        wait_issues(1, base, 10, ok);
        tests_run++; if (!ok || log_op[base] !== 4'h0 || log_addr[base] !== 4'd0) begin
            tests_failed++; $display("FAIL rw_restart: got ok=%b expected first issue addr 0 op 0", ok);
        end

        // Reset while halted.
        load_rom(32'h01A2B2E2);
        do_reset();
        instrReadyIn = 1'b1; enableIn = 1'b1;
        wait_halt(60, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL rh_halt_timeout: halt got 0 expected 1"); end
        reset = 1'b1;
        tick();
        tests_run++; if (pcOut !== 4'd0 || instrOut !== 4'b0111 || instrValidOut !== 1'b0 || haltOut !== 1'b0) begin
            tests_failed++; $display("FAIL rh_state: got pc=%0d instr=%h valid=%b halt=%b expected pc=0 instr=7 valid=0 halt=0", pcOut, instrOut, instrValidOut, haltOut);
        end
        reset = 1'b0;
        base = log_op.size();
        wait_issues(2, base, 10, ok);
        tests_run++; if (!ok || log_addr[base] !== 4'd0 || log_op[base+1] !== 4'h1) begin
            tests_failed++; $display("FAIL rh_restart: got ok=%b expected issues from addr 0 (ops 0,1)", ok);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 4'h0;
        test_reset();
        test_straight_line();
        test_snz_taken();
        test_snz_not_taken();
        test_backpressure();
        test_snz_at_end();
        test_reset_recovery();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
